// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, field positions and helpers
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  // J and JAL are the only opcodes resolved on the decode side
  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/decode/execute signals around the instruction queue
interface inst_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            f_valid;
  logic [XLEN-1:0] f_inst;
  logic [XLEN-1:0] f_pc;
  logic            f_ready;
  logic            d_valid;
  logic [XLEN-1:0] d_inst;
  logic [XLEN-1:0] d_pc4;
  logic            d_ready;
  logic            ex_redirect;
  logic            Jump;
  logic [XLEN-1:0] jump_target;
  logic [CW-1:0]   count;

  // pipeline side: fetch, decode and execute drive the queue
  modport master (
    output f_valid, f_inst, f_pc, d_ready, ex_redirect,
    input  f_ready, d_valid, d_inst, d_pc4, Jump, jump_target, count
  );

  // queue side
  modport slave (
    input  f_valid, f_inst, f_pc, d_ready, ex_redirect,
    output f_ready, d_valid, d_inst, d_pc4, Jump, jump_target, count
  );

endinterface

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - queue storage, one write port and one async read port
module inst_queue_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // storage is cleared on reset so an empty queue presents zeros to decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue with J/JAL resolution and squash
module inst_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = mips_pkg::XLEN
) (
  input logic         clk,
  input logic         reset,
  inst_queue_if.slave q
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              jump_q;
  logic [XLEN-1:0]   target_q, target_d;

  logic [2*XLEN-1:0] head;
  logic [2*XLEN-1:0] wdata;
  logic [XLEN-1:0]   head_inst;
  logic [XLEN-1:0]   head_pc4;
  logic              f_ready;
  logic              d_valid;
  logic              enq;
  logic              deq;
  logic              jump_deq;
  logic              squash;

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign head_inst = head[2*XLEN-1:XLEN];
  assign head_pc4  = head[XLEN-1:0];
  assign wdata     = {q.f_inst, q.f_pc + XLEN'(4)};

  // f_ready ignores a same-cycle dequeue; redirect hides the head from decode
  assign f_ready  = (count_q < FULL);
  assign d_valid  = (count_q != '0) && !q.ex_redirect;
  assign deq      = d_valid && q.d_ready;
  assign jump_deq = deq && is_jump(head_inst[OPCODE_MSB:OPCODE_LSB]);
  assign squash   = q.ex_redirect || jump_deq;
  assign enq      = q.f_valid && f_ready && !squash;

  assign q.f_ready     = f_ready;
  assign q.d_valid     = d_valid;
  assign q.d_inst      = head_inst;
  assign q.d_pc4       = head_pc4;
  assign q.Jump        = jump_q;
  assign q.jump_target = target_q;
  assign q.count       = count_q;

  // next pointers/count: squash empties the queue, otherwise track enq/deq
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    target_d = target_q;
    if (jump_deq) begin
      target_d = {head_pc4[XLEN-1:28], head_inst[25:0], 2'b00};
    end
    if (squash) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // state registers; reset also kills a pending Jump pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      jump_q   <= 1'b0;
      target_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      jump_q   <= jump_deq;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed scoreboard bench for inst_queue
module tb_inst_queue;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ent_t        sb[$];
  logic [31:0] exp_tgt = 32'h0;
  logic        exp_jump = 1'b0;

  inst_queue_if #(.XLEN(32), .DEPTH(2)) ifc ();

  inst_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed no_finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic op_is_jump(input logic [31:0] inst);
    return (inst[31:26] == 6'h02) || (inst[31:26] == 6'h03);
  endfunction

  // one clock: drive at posedge+1, check combinational outputs, then
  // check registered outputs just after the edge
  task automatic cycle(input logic fv, input logic [31:0] fi, input logic [31:0] fp,
                       input logic dr, input logic rd);
    logic exp_dv, deq, jd, enq;
    ent_t head;
    ifc.f_valid     = fv;
    ifc.f_inst      = fi;
    ifc.f_pc        = fp;
    ifc.d_ready     = dr;
    ifc.ex_redirect = rd;
    #2;
    chk(32'(ifc.f_ready), 32'(sb.size() < 2), "f_ready");
    exp_dv = (sb.size() != 0) && !rd;
    chk(32'(ifc.d_valid), 32'(exp_dv), "d_valid");
    head = '0;
    if (exp_dv) begin
      head = sb[0];
      chk(ifc.d_inst, head.inst, "d_inst");
      chk(ifc.d_pc4, head.pc4, "d_pc4");
    end
    deq = exp_dv && dr;
    jd  = deq && op_is_jump(head.inst);
    enq = fv && (sb.size() < 2) && !rd && !jd;
    if (jd) exp_tgt = {head.pc4[31:28], head.inst[25:0], 2'b00};
    exp_jump = jd;
    if (rd || jd) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back('{inst: fi, pc4: fp + 32'd4});
    end
    @(posedge clk);
    #1;
    chk(32'(ifc.Jump), 32'(exp_jump), "Jump");
    chk(ifc.jump_target, exp_tgt, "jump_target");
    chk(32'(ifc.count), 32'(sb.size()), "count");
  endtask

  task automatic check_reset_state(input string tag);
    chk(32'(ifc.count), 32'd0, {tag, "_count"});
    chk(32'(ifc.d_valid), 32'd0, {tag, "_d_valid"});
    chk(32'(ifc.f_ready), 32'd1, {tag, "_f_ready"});
    chk(32'(ifc.Jump), 32'd0, {tag, "_Jump"});
    chk(ifc.jump_target, 32'h0, {tag, "_jump_target"});
    chk(ifc.d_inst, 32'h0, {tag, "_d_inst"});
    chk(ifc.d_pc4, 32'h0, {tag, "_d_pc4"});
  endtask

  task automatic async_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    exp_tgt  = 32'h0;
    exp_jump = 1'b0;
    check_reset_state(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    ifc.f_valid     = 1'b0;
    ifc.f_inst      = 32'h0;
    ifc.f_pc        = 32'h0;
    ifc.d_ready     = 1'b0;
    ifc.ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    // fill, refuse when full, drain
    cycle(1'b1, 32'h20080001, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20090002, 32'h4, 1'b0, 1'b0);
    chk(32'(ifc.f_ready), 32'd0, "full_f_ready");
    chk(32'(ifc.count), 32'd2, "full_count");
    cycle(1'b1, 32'h200a0003, 32'h8, 1'b0, 1'b0);
    chk(32'(ifc.count), 32'd2, "refused_count");
    chk(ifc.d_pc4, 32'h4, "drain_first_pc4");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(ifc.d_pc4, 32'h8, "drain_second_pc4");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(32'(ifc.d_valid), 32'd0, "drained_d_valid");
    chk(32'(ifc.count), 32'd0, "drained_count");

    // streaming across pointer wrap
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h24000000 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      chk(32'(ifc.count), 32'd1, "stream_count");
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // J at 0x100 followed by an entry that must never be presented
    cycle(1'b1, 32'h08000010, 32'h100, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000000, 32'h104, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(32'(ifc.Jump), 32'd1, "j_pulse");
    chk(ifc.jump_target, 32'h00000040, "j_target");
    chk(32'(ifc.count), 32'd0, "j_empty");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(32'(ifc.Jump), 32'd0, "j_one_cycle");
    chk(ifc.jump_target, 32'h00000040, "j_target_hold");

    // JAL with a same-cycle enqueue offer that must be dropped
    cycle(1'b1, 32'h0c000100, 32'h10000200, 1'b0, 1'b0);
    cycle(1'b1, 32'h11111111, 32'h10000204, 1'b1, 1'b0);
    chk(ifc.jump_target, 32'h10000400, "jal_target");
    chk(32'(ifc.count), 32'd0, "jal_enq_dropped");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // redirect beats a jump at the head and drops the enqueue
    cycle(1'b1, 32'h08000020, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h20000005, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h20000006, 32'h308, 1'b1, 1'b1);
    chk(32'(ifc.count), 32'd0, "redir_count");
    chk(32'(ifc.Jump), 32'd0, "redir_no_jump");
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // async reset with a full queue
    cycle(1'b1, 32'h20000007, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h20000008, 32'h404, 1'b0, 1'b0);
    async_reset("rst_full");

    // async reset while the Jump pulse is high
    cycle(1'b1, 32'h08000030, 32'h500, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk(32'(ifc.Jump), 32'd1, "pre_rst_jump");
    async_reset("rst_jump");
    cycle(1'b1, 32'h2000000a, 32'h600, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
